// File: rtl/gemm_tile_ctrl.sv
// rtl/gemm_tile_ctrl.sv - tile sequencer for the output-stationary MAC PE
//
// Walks (m, n, k) tile indices with k innermost, issues A/B SRAM reads,
// drives PE init_save/valid one cycle after each issue and writes each
// finished C tile two cycles after its last K issue.
// Optional build macro: GEMM_CTRL_STALL_EN adds stall_i (holds issue in RUN).
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                job start, sampled only in IDLE
//   m/n/k_size_i           tile counts, latched on accepted start
//   stall_i                (GEMM_CTRL_STALL_EN only) suppress issue in RUN
//   mem_req_o              A/B SRAM read enable
//   a_addr_o, b_addr_o     A (m*K+k) and B (k*N+n) read addresses
//   pe_valid_o             PE accumulate step
//   pe_init_save_o         PE first K step of a tile
//   c_wr_o, c_addr_o       C write enable and address (m*N+n)
//   busy_o                 high in RUN and DRAIN
//   done_o                 one-cycle end-of-job pulse
module gemm_tile_ctrl #(
   parameter int SizeWidth = 16,
   parameter int AddrWidth = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [SizeWidth-1:0] m_size_i,
   input  logic [SizeWidth-1:0] n_size_i,
   input  logic [SizeWidth-1:0] k_size_i,
`ifdef GEMM_CTRL_STALL_EN
   input  logic                 stall_i,
`endif
   output logic                 mem_req_o,
   output logic [AddrWidth-1:0] a_addr_o,
   output logic [AddrWidth-1:0] b_addr_o,
   output logic                 pe_valid_o,
   output logic                 pe_init_save_o,
   output logic                 c_wr_o,
   output logic [AddrWidth-1:0] c_addr_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [SizeWidth-1:0] SOne = 1;
   localparam logic [AddrWidth-1:0] AOne = 1;

   state_t               state;
   logic [SizeWidth-1:0] m_sz, n_sz, k_sz;
   logic [SizeWidth-1:0] m_idx, n_idx, k_idx;
   logic [AddrWidth-1:0] a_row;    // m*K, start of the current A row
   logic [AddrWidth-1:0] c_cur;    // m*N+n of the tile being issued
   logic                 req_q;
   logic                 drain_cnt;
   logic                 p1_last;
   logic [AddrWidth-1:0] p1_caddr;
   logic                 issue;
   logic                 k_first, k_last, n_last, m_last;

`ifdef GEMM_CTRL_STALL_EN
   // Stall gates the issue in the same cycle; indices hold until it drops.
   assign issue = req_q & ~stall_i;
`else
   assign issue = req_q;
`endif

   assign mem_req_o = issue;
   assign k_first   = (k_idx == '0);
   assign k_last    = (k_idx == k_sz - SOne);
   assign n_last    = (n_idx == n_sz - SOne);
   assign m_last    = (m_idx == m_sz - SOne);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state          <= IDLE;
         m_sz           <= '0;
         n_sz           <= '0;
         k_sz           <= '0;
         m_idx          <= '0;
         n_idx          <= '0;
         k_idx          <= '0;
         a_addr_o       <= '0;
         b_addr_o       <= '0;
         a_row          <= '0;
         c_cur          <= '0;
         req_q          <= 1'b0;
         drain_cnt      <= 1'b0;
         p1_last        <= 1'b0;
         p1_caddr       <= '0;
         pe_valid_o     <= 1'b0;
         pe_init_save_o <= 1'b0;
         c_wr_o         <= 1'b0;
         c_addr_o       <= '0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
      end else begin
         // Issue pipeline: PE step one cycle after issue, C write one after that.
         pe_init_save_o <= issue & k_first;
         pe_valid_o     <= issue & ~k_first;
         p1_last        <= issue & k_last;
         p1_caddr       <= c_cur;
         c_wr_o         <= p1_last;
         c_addr_o       <= p1_last ? p1_caddr : '0;
         done_o         <= 1'b0;

         case (state)
            IDLE: begin
               if (start_i) begin
                  m_sz     <= m_size_i;
                  n_sz     <= n_size_i;
                  k_sz     <= k_size_i;
                  m_idx    <= '0;
                  n_idx    <= '0;
                  k_idx    <= '0;
                  a_addr_o <= '0;
                  b_addr_o <= '0;
                  a_row    <= '0;
                  c_cur    <= '0;
                  if (m_size_i == '0 || n_size_i == '0 || k_size_i == '0) begin
                     state <= DONE;
                  end else begin
                     state  <= RUN;
                     req_q  <= 1'b1;
                     busy_o <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  if (k_last && n_last && m_last) begin
                     state     <= DRAIN;
                     req_q     <= 1'b0;
                     drain_cnt <= 1'b0;
                  end else if (!k_last) begin
                     k_idx    <= k_idx + SOne;
                     a_addr_o <= a_addr_o + AOne;
                     b_addr_o <= b_addr_o + AddrWidth'(n_sz);
                  end else begin
                     k_idx <= '0;
                     c_cur <= c_cur + AOne;
                     if (!n_last) begin
                        n_idx    <= n_idx + SOne;
                        a_addr_o <= a_row;
                        b_addr_o <= AddrWidth'(n_idx) + AOne;
                     end else begin
                        // Last A address of the row plus one is the next row base.
                        n_idx    <= '0;
                        m_idx    <= m_idx + SOne;
                        a_addr_o <= a_addr_o + AOne;
                        a_row    <= a_addr_o + AOne;
                        b_addr_o <= '0;
                     end
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt) begin
                  state  <= DONE;
                  busy_o <= 1'b0;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_o <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
